// File: rtl/random_range_gen.sv
// Multi-lane Galois-LFSR random source with bit interleaving, reseeding and a
// rejection-sampling draw engine that returns uniform values in [0, limit).
module random_range_gen #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       LANES     = 8,
  parameter logic [WIDTH-1:0]  TAPS      = 8'hB8,
  parameter int unsigned       MAX_TRIES = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   seed_load,
  input  logic [LANES*WIDTH-1:0] seeds,
  input  logic                   req,
  input  logic [WIDTH-1:0]       limit,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       data,
  output logic                   fallback
);

  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [0:0] {StIdle, StDraw} state_e;

  logic [LANES-1:0][WIDTH-1:0] lane_q, lane_d;
  logic [WIDTH-1:0]            rand_word;
  logic [WIDTH-1:0]            lim_m1, mask;
  logic [WIDTH-1:0]            lim_q, mask_q;
  logic [WIDTH-1:0]            cand, fb_val;
  logic                        accept;
  logic [TW-1:0]               tries_q;
  state_e                      state_q;

  // Reset value of lane k: k+1, with zero (the lock-up state) replaced by 1.
  function automatic logic [WIDTH-1:0] reset_val(input int unsigned k);
    logic [WIDTH-1:0] v;
    v = WIDTH'(k + 1);
    if (v == '0) v = WIDTH'(1);
    return v;
  endfunction

  // Next lane state: reload from seeds (zero forced to 1) or one Galois step.
  always_comb begin
    lane_d = lane_q;
    for (int k = 0; k < int'(LANES); k++) begin
      if (seed_load) begin
        lane_d[k] = (seeds[k*WIDTH +: WIDTH] == '0) ? WIDTH'(1) : seeds[k*WIDTH +: WIDTH];
      end else begin
        lane_d[k] = lane_q[k][0] ? ((lane_q[k] >> 1) ^ TAPS) : (lane_q[k] >> 1);
      end
    end
  end

  // Lane registers free-run every clock.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < LANES; k++) lane_q[k] <= reset_val(k);
    end else begin
      lane_q <= lane_d;
    end
  end

  // Interleave: output bit i comes from bit i of lane (i mod LANES).
  always_comb begin
    rand_word = '0;
    for (int i = 0; i < int'(WIDTH); i++) rand_word[i] = lane_q[i % LANES][i];
  end

  // Smear-right of limit-1; limit==0 wraps to all-ones, which is the full-range mask.
  always_comb begin
    lim_m1 = limit - WIDTH'(1);
    mask   = '0;
    mask[WIDTH-1] = lim_m1[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) mask[i] = mask[i+1] | lim_m1[i];
  end

  // Attempt evaluation against the latched bound and mask.
  always_comb begin
    cand   = rand_word & mask_q;
    accept = (lim_q == '0) || (cand < lim_q);
    // mask < 2*limit, so a rejected candidate minus limit is always in range.
    fb_val = cand - lim_q;
  end

  // Draw FSM with registered busy/done/data/fallback.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      lim_q    <= '0;
      mask_q   <= '0;
      tries_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data     <= '0;
      fallback <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // seed_load wins over req; req is re-sampled next cycle.
          if (req && !seed_load) begin
            state_q <= StDraw;
            lim_q   <= limit;
            mask_q  <= mask;
            tries_q <= '0;
            busy    <= 1'b1;
          end
        end
        StDraw: begin
          if (seed_load) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (accept) begin
            data     <= cand;
            done     <= 1'b1;
            fallback <= 1'b0;
            state_q  <= StIdle;
            busy     <= 1'b0;
          end else if (tries_q == TW'(MAX_TRIES - 1)) begin
            data     <= fb_val;
            done     <= 1'b1;
            fallback <= 1'b1;
            state_q  <= StIdle;
            busy     <= 1'b0;
          end else begin
            tries_q <= tries_q + TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_range_gen.sv
// Bench for random_range_gen: per-cycle comparison against a behavioural model,
// plus hand-computed literal expectations and a distribution check.
module tb_random_range_gen;

  localparam int W  = 8;
  localparam int L  = 8;
  localparam int MT = 16;

  logic           clock = 1'b0;
  logic           resetn;
  logic           seed_load, req;
  logic [L*W-1:0] seeds;
  logic [W-1:0]   limit;
  logic           busy, done, fallback;
  logic [W-1:0]   data;

  logic           seed_load2, req2;
  logic [L*W-1:0] seeds2;
  logic [W-1:0]   limit2;
  logic           busy2, done2, fallback2;
  logic [W-1:0]   data2;

  random_range_gen #(.WIDTH(W), .LANES(L), .TAPS(8'hB8), .MAX_TRIES(MT)) dut (
    .clock(clock), .resetn(resetn), .seed_load(seed_load), .seeds(seeds), .req(req),
    .limit(limit), .busy(busy), .done(done), .data(data), .fallback(fallback)
  );

  random_range_gen #(.WIDTH(W), .LANES(L), .TAPS(8'hB8), .MAX_TRIES(1)) dut1 (
    .clock(clock), .resetn(resetn), .seed_load(seed_load2), .seeds(seeds2), .req(req2),
    .limit(limit2), .busy(busy2), .done(done2), .data(data2), .fallback(fallback2)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         ml[L];
  bit         m_draw;
  int         m_lim, m_mask, m_tries, m_w, m_v;
  logic       e_busy, e_done, e_fb;
  logic [7:0] e_data;

  function automatic int lfsr_step(input int s);
    if (s % 2 == 1) return (s >> 1) ^ 'hB8;
    return s >> 1;
  endfunction

  function automatic int word_of();
    int w = 0;
    for (int i = 0; i < W; i++) if (((ml[i % L] >> i) & 1) == 1) w += (1 << i);
    return w;
  endfunction

  // Smallest 2^k-1 covering limit-1; full range for limit 0.
  function automatic int mask_for(input int lim);
    int m = 0;
    if (lim == 0) return 255;
    while (m < lim - 1) m = m * 2 + 1;
    return m;
  endfunction

  initial forever begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      for (int k = 0; k < L; k++) ml[k] = (((k + 1) % 256) == 0) ? 1 : (k + 1) % 256;
      m_draw = 0; m_tries = 0;
      e_busy = 0; e_done = 0; e_data = 0; e_fb = 0;
    end else begin
      m_w    = word_of();
      e_done = 0;
      if (seed_load) begin
        for (int k = 0; k < L; k++) ml[k] = (seeds[k*W +: W] == 0) ? 1 : int'(seeds[k*W +: W]);
        m_draw = 0;
      end else begin
        for (int k = 0; k < L; k++) ml[k] = lfsr_step(ml[k]);
        if (!m_draw) begin
          if (req) begin
            m_draw = 1; m_lim = int'(limit); m_mask = mask_for(int'(limit)); m_tries = 0;
          end
        end else begin
          m_v = m_w & m_mask;
          if (m_lim == 0 || m_v < m_lim) begin
            e_data = 8'(m_v); e_done = 1; e_fb = 0; m_draw = 0;
          end else if (m_tries == MT - 1) begin
            e_data = 8'(m_v - m_lim); e_done = 1; e_fb = 1; m_draw = 0;
          end else begin
            m_tries++;
          end
        end
      end
      e_busy = m_draw;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clock);
    if (chk_en && resetn) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("data", data, e_data);
      chk("fallback", fallback, e_fb);
      for (int k = 0; k < L; k++) chk("lane", dut.lane_q[k], ml[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_draw(input logic [7:0] lim, output int lat);
    bit ok = 0;
    limit = lim; req = 1'b1; lat = 0;
    for (int c = 0; c < MT + 4; c++) begin
      @(negedge clock);
      lat++;
      limit = 8'($urandom);  // latched copy must be used
      if (done) begin ok = 1; break; end
    end
    req = 1'b0;
    if (!ok) chk("draw_timeout", 0, 1);
  endtask

  int         lat;
  int         cnt[6];
  logic [7:0] saved;

  initial begin
    resetn = 1'b0; seed_load = 1'b0; req = 1'b0; seeds = '0; limit = '0;
    seed_load2 = 1'b0; req2 = 1'b0; seeds2 = '0; limit2 = '0;

    // Reset state
    @(negedge clock);
    for (int k = 0; k < L; k++) chk("rst_lane", dut.lane_q[k], k + 1);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_data", data, 0); chk("rst_fb", fallback, 0);
    chk("rst_busy2", busy2, 0); chk("rst_data2", data2, 0);

    // Release with req low: lanes step, outputs static
    resetn = 1'b1; chk_en = 1'b1;
    @(negedge clock);
    chk("lane0_first_step", dut.lane_q[0], 8'hB8);
    repeat (3) @(negedge clock);

    // limit=0 draw straight after reset: DRAW-cycle word is 8'h10
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1; req = 1'b1; limit = 8'd0;
    @(negedge clock);
    req = 1'b0;
    chk("l0_busy", busy, 1); chk("l0_done_early", done, 0);
    @(negedge clock);
    chk("l0_done", done, 1); chk("l0_busy_clr", busy, 0);
    chk("l0_data", data, 8'h10); chk("l0_fb", fallback, 0);
    @(negedge clock);
    chk("l0_done_pulse", done, 0);

    // Seed all lanes with 1: lane0 period is exactly 255
    seeds = {L{8'h01}}; seed_load = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;
    chk("seed_lane0", dut.lane_q[0], 1);
    for (int j = 1; j <= 255; j++) begin
      @(negedge clock);
      if (j < 255) chk("lane0_not0_not1", (dut.lane_q[0] != 0) && (dut.lane_q[0] != 1), 1);
      else         chk("lane0_period255", dut.lane_q[0], 1);
    end

    // Zero seed on lane 3 loads 1
    seeds = {$urandom, $urandom}; seeds[3*W +: W] = 8'h00; seed_load = 1'b1;
    @(negedge clock);
    seed_load = 1'b0;
    chk("zero_seed_lane3", dut.lane_q[3], 1);

    // limit=1: always 0 on first attempt
    for (int n = 0; n < 50; n++) begin
      do_draw(8'd1, lat);
      chk("lim1_data", data, 0);
      chk("lim1_latency", lat, 2);
    end

    // limit=6 distribution
    for (int v = 0; v < 6; v++) cnt[v] = 0;
    for (int n = 0; n < 2000; n++) begin
      do_draw(8'd6, lat);
      chk("lim6_range", data < 6, 1);
      if (data < 6) cnt[data]++;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    for (int v = 0; v < 6; v++) chk("lim6_hits_ge250", cnt[v] >= 250, 1);

    // MAX_TRIES=1, limit=5, seeds step to 8'hFF -> fallback 7-5=2.
    // seed_load with req: draw starts one cycle later.
    seeds2 = {L{8'h8F}}; seed_load2 = 1'b1; req2 = 1'b1; limit2 = 8'd5;
    @(negedge clock);
    seed_load2 = 1'b0;
    chk("mt1_busy_delayed", busy2, 0);
    @(negedge clock);
    req2 = 1'b0;
    chk("mt1_busy", busy2, 1);
    @(negedge clock);
    chk("mt1_done", done2, 1); chk("mt1_data", data2, 2);
    chk("mt1_fb", fallback2, 1); chk("mt1_busy_clr", busy2, 0);

    // seed_load with req in IDLE on the main instance
    seeds = {$urandom, $urandom}; seed_load = 1'b1; req = 1'b1; limit = 8'd200;
    @(negedge clock);
    seed_load = 1'b0;
    chk("sl_prio_busy0", busy, 0);
    @(negedge clock);
    req = 1'b0;
    chk("sl_prio_busy1", busy, 1);
    repeat (MT + 2) @(negedge clock);

    // seed_load mid-DRAW aborts without done
    saved = e_data;
    req = 1'b1; limit = 8'd0;
    @(negedge clock);
    req = 1'b0; seeds = {$urandom, $urandom}; seed_load = 1'b1;
    chk("abort_in_draw", busy, 1);
    @(negedge clock);
    seed_load = 1'b0;
    chk("abort_done", done, 0); chk("abort_busy", busy, 0); chk("abort_data", data, saved);

    // Reset mid-draw: immediate return to reset values
    req = 1'b1; limit = 8'd200;
    @(negedge clock);
    req = 1'b0;
    chk("pre_reset_busy", busy, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_data", data, 0); chk("mid_rst_fb", fallback, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      req       = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 15) == 0);
      seeds     = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) seeds[$urandom_range(0, L - 1)*W +: W] = 8'h00;
      case ($urandom_range(0, 4))
        0:       limit = 8'd0;
        1:       limit = 8'd1;
        2:       limit = 8'd128;
        3:       limit = 8'd255;
        default: limit = 8'($urandom);
      endcase
    end
    req = 1'b0; seed_load = 1'b0;
    repeat (MT + 2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
